// File: rtl/krnl_partialknn_local_sp_ctrl_pkg.sv
// Shared types, default sizing and the length clamp for the partialKnn local
// single-port search-space controller.
package krnl_partialknn_local_sp_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 256;
    localparam int unsigned ADDR_RANGE_DEF   = 2048;
    localparam int unsigned ADDR_WIDTH_DEF   = 11;
    localparam int unsigned READ_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned range);
        return (len > range) ? range : len;
    endfunction

endpackage

// File: rtl/krnl_partialknn_local_sp_ctrl_fifo.sv
// Small synchronous FIFO holding returned words plus their last flag; the
// count is exported so the controller can reserve space before issuing reads.
module krnl_partialknn_local_sp_ctrl_fifo
    import krnl_partialknn_local_sp_ctrl_pkg::*;
#(
    parameter int unsigned Width = 257,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q != CntW'(Depth));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/krnl_partialknn_local_sp_ctrl.sv
// Loads a block into the single-port buffer, then replays it a number of
// passes through a credit-protected output FIFO.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | writing the input stream into the buffer
//   READ   | issuing reads while FIFO credit is available
//   DRAIN  | waiting for in-flight reads and the FIFO to empty
//   DONE   | one-cycle completion pulse
module krnl_partialknn_local_sp_ctrl
    import krnl_partialknn_local_sp_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth    = DATA_WIDTH_DEF,
    parameter int unsigned AddressRange = ADDR_RANGE_DEF,
    parameter int unsigned AddressWidth = ADDR_WIDTH_DEF,
    parameter int unsigned ReadLatency  = READ_LATENCY_DEF,
    parameter int unsigned FifoDepth    = ReadLatency + 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [AddressWidth:0]   cfg_len_i,
    input  logic [7:0]              cfg_passes_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic [DataWidth-1:0]    in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DataWidth-1:0]    out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    output logic [AddressWidth-1:0] mem_address0_o,
    output logic                    mem_ce0_o,
    output logic                    mem_we0_o,
    output logic [DataWidth-1:0]    mem_d0_o,
    input  logic [DataWidth-1:0]    mem_q0_i
);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    typedef logic [AddressWidth:0] len_t;

    state_e                  state_q, state_d;
    len_t                    len_q, len_d;
    logic [7:0]              passes_q, passes_d;
    logic [7:0]              pass_cnt_q, pass_cnt_d;
    logic [AddressWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddressWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [ReadLatency-1:0]  issue_sr_q, last_sr_q;

    len_t            len_clamped, last_addr;
    logic            wr_last, rd_last, pass_last;
    logic [CntW-1:0] outstanding, fifo_count;
    logic            credit_ok, issue, issue_last, drain_empty;
    logic            fifo_pop, fifo_valid;
    logic [DataWidth:0] fifo_rdata;

    assign len_clamped = len_t'(clamp_len(32'(cfg_len_i), AddressRange));
    assign last_addr   = len_q - len_t'(1);
    assign wr_last     = ({1'b0, wr_ptr_q} == last_addr);
    assign rd_last     = ({1'b0, rd_ptr_q} == last_addr);
    assign pass_last   = (pass_cnt_q == (passes_q - 8'd1));

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < int'(ReadLatency); i++) begin
            outstanding = outstanding + CntW'(issue_sr_q[i]);
        end
    end

    // Credit counts words still in the memory pipe, so a full FIFO can never be overrun.
    assign credit_ok   = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CntW + 1)'(FifoDepth);
    assign fifo_pop    = fifo_valid && out_ready_i;
    assign drain_empty = (outstanding == '0) &&
                         ((fifo_count == '0) || ((fifo_count == CntW'(1)) && fifo_pop));

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        passes_d       = passes_q;
        pass_cnt_d     = pass_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        issue          = 1'b0;
        issue_last     = 1'b0;
        in_ready_o     = 1'b0;
        mem_ce0_o      = 1'b0;
        mem_we0_o      = 1'b0;
        mem_address0_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d      = len_clamped;
                    passes_d   = cfg_passes_i;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    pass_cnt_d = '0;
                    state_d    = (len_clamped == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mem_ce0_o      = 1'b1;
                    mem_we0_o      = 1'b1;
                    mem_address0_o = wr_ptr_q;
                    wr_ptr_d       = wr_ptr_q + AddressWidth'(1);
                    if (wr_last) begin
                        state_d = (passes_q != 8'd0) ? ST_READ : ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue          = 1'b1;
                    issue_last     = rd_last;
                    mem_ce0_o      = 1'b1;
                    mem_address0_o = rd_ptr_q;
                    if (rd_last) begin
                        rd_ptr_d   = '0;
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        if (pass_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AddressWidth'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            issue_sr_q <= '0;
            last_sr_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            issue_sr_q <= (issue_sr_q << 1) | ReadLatency'(issue);
            last_sr_q  <= (last_sr_q << 1) | ReadLatency'(issue_last);
        end
    end

    krnl_partialknn_local_sp_ctrl_fifo #(
        .Width (DataWidth + 1),
        .Depth (FifoDepth),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (issue_sr_q[ReadLatency-1]),
        .data_i  ({last_sr_q[ReadLatency-1], mem_q0_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign mem_d0_o    = in_data_i;
    assign out_valid_o = fifo_valid;
    assign out_data_o  = fifo_rdata[DataWidth-1:0];
    assign out_last_o  = fifo_valid && fifo_rdata[DataWidth];

endmodule
